// File: rtl/pwm_multi_ch.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_ch
// Brief    : Multi-channel PWM generator. One shared period counter drives
//            CH duty comparators. Each channel has a double-buffered duty
//            target, an optional linear duty ramp and a glitch-free enable.
//            Period, duty and enable changes all land on period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi_ch #(
    parameter int CH             = 4,
    parameter int CNT_W          = 16,
    parameter int DEFAULT_PERIOD = 100,
    localparam int C_CH_W        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CH-1:0]     en,
    input  logic              wr_en,
    input  logic [1:0]        wr_sel,
    input  logic [C_CH_W-1:0] wr_ch,
    input  logic [CNT_W-1:0]  wr_data,
    output logic [CH-1:0]     pwm,
    output logic              period_tick,
    output logic [CH-1:0]     ramp_busy
);

    localparam logic [CNT_W-1:0] c_DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);
    localparam logic [1:0]       c_SEL_PERIOD = 2'd0;
    localparam logic [1:0]       c_SEL_DUTY   = 2'd1;
    localparam logic [1:0]       c_SEL_STEP   = 2'd2;

    logic [CNT_W-1:0] r_period_reg;
    logic [CNT_W-1:0] r_period_q;
    logic [CNT_W-1:0] r_cnt;
    logic [CH-1:0]    r_en_q;
    logic             r_tick;
    logic             w_period_zero;
    logic             w_boundary;

    // A zero period makes every cycle a boundary so staging keeps flowing
    // into the active registers while the outputs stay parked low.
    assign w_period_zero = (r_period_q == '0);
    assign w_boundary    = w_period_zero || (r_cnt == (r_period_q - CNT_W'(1)));
    assign period_tick   = r_tick;

    // Period staging register, written through the config interface.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_period_reg <= c_DEF_PERIOD;
        end else if (wr_en && (wr_sel == c_SEL_PERIOD)) begin
            r_period_reg <= wr_data;
        end
    end

    // Shared period counter; loads active period and enables at each boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_period_q <= c_DEF_PERIOD;
            r_en_q     <= '0;
            r_tick     <= 1'b0;
        end else begin
            // Tick marks the cnt==0 cycle after a real wrap; never in period 0.
            r_tick <= w_boundary && !w_period_zero;
            if (w_boundary) begin
                r_cnt      <= '0;
                r_period_q <= r_period_reg;
                r_en_q     <= en;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_duty_tgt;
        logic [CNT_W-1:0] r_step;
        logic [CNT_W-1:0] r_duty_q;
        logic             r_pwm;
        logic [CNT_W:0]   w_up;
        logic [CNT_W:0]   w_dn;
        logic [CNT_W-1:0] w_duty_next;
        logic             w_sel_me;

        // An out-of-range channel index simply matches no channel.
        assign w_sel_me = wr_en && (wr_ch == C_CH_W'(i));

        // Per-channel staging registers: duty target and ramp step.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_duty_tgt <= '0;
                r_step     <= '0;
            end else if (w_sel_me) begin
                if (wr_sel == c_SEL_DUTY) begin
                    r_duty_tgt <= wr_data;
                end else if (wr_sel == c_SEL_STEP) begin
                    r_step <= wr_data;
                end
            end
        end

        // Next active duty: jump when step is 0, else move by step and clamp
        // at the target. One extra bit keeps the sum and difference exact.
        always_comb begin
            w_up        = {1'b0, r_duty_q} + {1'b0, r_step};
            w_dn        = {1'b0, r_duty_q} - {1'b0, r_step};
            w_duty_next = r_duty_tgt;
            if (r_step != '0) begin
                if (r_duty_q < r_duty_tgt) begin
                    if (w_up < {1'b0, r_duty_tgt}) begin
                        w_duty_next = w_up[CNT_W-1:0];
                    end
                end else if (r_duty_q > r_duty_tgt) begin
                    if (!w_dn[CNT_W] && (w_dn > {1'b0, r_duty_tgt})) begin
                        w_duty_next = w_dn[CNT_W-1:0];
                    end
                end
            end
        end

        // Active duty only advances at a boundary.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_duty_q <= '0;
            end else if (w_boundary) begin
                r_duty_q <= w_duty_next;
            end
        end

        // Registered comparator output; duty >= period gives a solid high.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_pwm <= 1'b0;
            end else begin
                r_pwm <= r_en_q[i] && !w_period_zero && (r_cnt < r_duty_q);
            end
        end

        assign pwm[i]       = r_pwm;
        assign ramp_busy[i] = (r_duty_q != r_duty_tgt);
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_ch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi_ch
// Brief    : Scoreboard bench for pwm_multi_ch. Stimulus queues the expected
//            per-period high counts, period length and ramp_busy state; a
//            monitor integrates pwm over each tick-delimited window and pops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_ch;

    logic        clk;
    logic        reset;
    logic [3:0]  en;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [1:0]  wr_ch;
    logic [15:0] wr_data;
    logic [3:0]  pwm;
    logic        period_tick;
    logic [3:0]  ramp_busy;

    pwm_multi_ch #(
        .CH             (4),
        .CNT_W          (16),
        .DEFAULT_PERIOD (100)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_ch       (wr_ch),
        .wr_data     (wr_data),
        .pwm         (pwm),
        .period_tick (period_tick),
        .ramp_busy   (ramp_busy)
    );

    typedef struct packed {
        logic [15:0]      len;
        logic [3:0][15:0] hi;
        logic [3:0]       busy;
    } rec_t;

    rec_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_cnt;
    int   acc_len;
    int   acc_hi[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic void push(input int len, input int h0, input int h1,
                                 input int h2, input int h3, input logic [3:0] b);
        rec_t r;
        r.len   = 16'(len);
        r.hi[0] = 16'(h0);
        r.hi[1] = 16'(h1);
        r.hi[2] = 16'(h2);
        r.hi[3] = 16'(h3);
        r.busy  = b;
        q.push_back(r);
    endfunction

    // Edges since reset release, for latency checks.
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    // Monitor: the window closed by a tick covers one full period of pwm.
    always @(negedge clk) begin
        if (!reset) begin
            acc_len = 0;
            for (int i = 0; i < 4; i++) acc_hi[i] = 0;
        end else begin
            acc_len++;
            for (int i = 0; i < 4; i++) acc_hi[i] += int'(pwm[i]);
            if (period_tick) begin
                if (q.size() > 0) begin
                    rec_t e;
                    e = q.pop_front();
                    check("period_len", acc_len, e.len);
                    for (int i = 0; i < 4; i++)
                        check($sformatf("high_ch%0d", i), acc_hi[i], e.hi[i]);
                    check("busy_at_wrap", period_tick ? ramp_busy : 4'hx, e.busy);
                end
                acc_len = 0;
                for (int i = 0; i < 4; i++) acc_hi[i] = 0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic skip(input int n);
        for (int k = 0; k < n; k++) next_cycle();
    endtask

    task automatic write(input logic [1:0] sel, input logic [1:0] ch, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_ch   = ch;
        wr_data = d;
        next_cycle();
        wr_en   = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            next_cycle();
            if (period_tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout_fail(name);
    endtask

    initial begin
        int hi_cnt;
        int tick_cnt;
        int first_tick;
        reset   = 1'b0;
        en      = 4'b0000;
        wr_en   = 1'b0;
        wr_sel  = 2'd0;
        wr_ch   = 2'd0;
        wr_data = 16'd0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // Reset state
        check("reset_pwm", pwm, 0);
        check("reset_busy", ramp_busy, 0);
        check("reset_tick", period_tick, 0);

        // Period 1: stage ch0 duty 30 and enable it
        next_cycle();
        write(2'd1, 2'd0, 16'd30);
        check("busy_after_write", ramp_busy, 4'b0001);
        en = 4'b0001;
        wait_tick("tick1");
        check("first_tick_edges", edge_cnt, 100);

        // Period 2: queue expectations, start ramps on ch1 (0->60) and ch2 (0->50)
        next_cycle();
        check("busy_p2", ramp_busy, 4'b0000);
        push(100, 30,  0,  0,   0, 4'b0110);
        push(100, 30, 20, 20,   0, 4'b0110);
        push(100, 30, 40, 40,   0, 4'b0000);
        push(100, 30, 60, 50,   0, 4'b0000);
        push(100, 30, 60, 50, 100, 4'b0000);
        push(100,  0, 60, 50, 100, 4'b0000);
        push(100, 30, 60, 50, 100, 4'b0000);
        push( 50,  0, 50, 50,  50, 4'b0000);
        write(2'd2, 2'd1, 16'd20);
        write(2'd1, 2'd1, 16'd60);
        write(2'd2, 2'd2, 16'd20);
        write(2'd1, 2'd2, 16'd50);
        en = 4'b0111;
        wait_tick("tick_p3");
        wait_tick("tick_p4");
        wait_tick("tick_p5");

        // Period 5: ch3 duty equal to the period
        next_cycle();
        write(2'd1, 2'd3, 16'd100);
        en = 4'b1111;
        wait_tick("tick_p6");

        // Period 6: ch3 duty max, ch0 duty 0
        next_cycle();
        write(2'd1, 2'd3, 16'hFFFF);
        write(2'd1, 2'd0, 16'd0);
        wait_tick("tick_p7");

        // Period 7: restore ch0 duty 30
        next_cycle();
        write(2'd1, 2'd0, 16'd30);
        wait_tick("tick_p8");

        // Period 8: at cnt 40 write period 50 and drop en[0]
        skip(40);
        en = 4'b1110;
        write(2'd0, 2'd0, 16'd50);
        wait_tick("tick_p9");

        // Period 9: stage period 0
        next_cycle();
        write(2'd0, 2'd0, 16'd0);
        for (int k = 0; k < 200 && q.size() > 0; k++) next_cycle();
        if (q.size() > 0) timeout_fail("scoreboard_drain");

        // Period 0: outputs parked low, no ticks
        hi_cnt   = 0;
        tick_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            next_cycle();
            if (pwm != 4'b0000) hi_cnt++;
            if (period_tick) tick_cnt++;
        end
        check("p0_pwm_high_cycles", hi_cnt, 0);
        check("p0_ticks", tick_cnt, 0);

        // Period 1: tick continuously high
        write(2'd0, 2'd0, 16'd1);
        skip(3);
        tick_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (period_tick) tick_cnt++;
            next_cycle();
        end
        check("p1_ticks", tick_cnt, 20);

        // Back to period 100, ramp ch1 down by 5, reset at cnt 37
        write(2'd0, 2'd0, 16'd100);
        skip(3);
        write(2'd2, 2'd1, 16'd5);
        write(2'd1, 2'd1, 16'd0);
        wait_tick("tick_ramp");
        skip(37);
        check("pre_reset_pwm", pwm, 4'b1110);
        check("pre_reset_busy", ramp_busy, 4'b0010);
        #1 reset = 1'b0;
        #1;
        check("async_reset_pwm", pwm, 0);
        check("async_reset_busy", ramp_busy, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // After release: no residual pulse, first tick 100 edges later
        hi_cnt     = 0;
        first_tick = -1;
        for (int k = 0; k < 250; k++) begin
            next_cycle();
            if (pwm != 4'b0000) hi_cnt++;
            if (period_tick && first_tick < 0) first_tick = edge_cnt;
        end
        check("post_reset_pwm_high_cycles", hi_cnt, 0);
        check("post_reset_first_tick", first_tick, 100);
        check("post_reset_busy", ramp_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
